// File: rtl/adam_axil_req_mst.sv
// AXI-Lite master: turns a valid/ready request/response port into single AXI-Lite
// write (AW+W+B) or read (AR+R) transactions, one outstanding, with pause handshake.
//
// state | meaning
// IDLE  | waiting for a request; only state that accepts requests or acks pause
// WR    | AW and W presented; each drops after its own handshake
// WB    | waiting for the write response on B
// RD    | AR presented until ar_ready
// RR    | waiting for read data on R
// RSP   | response held on rsp_* until rsp_ready
module adam_axil_req_mst #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_pause_req,
   output logic                      o_pause_ack,
   input  logic                      i_req_we,
   input  logic [ADDR_WIDTH-1:0]     i_req_addr,
   input  logic [2:0]                i_req_prot,
   input  logic [DATA_WIDTH-1:0]     i_req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_req_strb,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
   output logic [1:0]                o_rsp_resp,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [ADDR_WIDTH-1:0]     o_aw_addr,
   output logic [2:0]                o_aw_prot,
   output logic                      o_aw_valid,
   input  logic                      i_aw_ready,
   output logic [DATA_WIDTH-1:0]     o_w_data,
   output logic [DATA_WIDTH/8-1:0]   o_w_strb,
   output logic                      o_w_valid,
   input  logic                      i_w_ready,
   input  logic [1:0]                i_b_resp,
   input  logic                      i_b_valid,
   output logic                      o_b_ready,
   output logic [ADDR_WIDTH-1:0]     o_ar_addr,
   output logic [2:0]                o_ar_prot,
   output logic                      o_ar_valid,
   input  logic                      i_ar_ready,
   input  logic [DATA_WIDTH-1:0]     i_r_data,
   input  logic [1:0]                i_r_resp,
   input  logic                      i_r_valid,
   output logic                      o_r_ready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WB,
      S_RD,
      S_RR,
      S_RSP
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_aw_valid;
   logic                    r_w_valid;
   logic                    r_ar_valid;
   logic                    r_pause_ack;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [2:0]              r_prot;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_WIDTH-1:0]   r_strb;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [1:0]              r_resp;
   logic                    w_req_hs;
   logic                    w_aw_done;
   logic                    w_w_done;

   // Ready is gated by reset so a request held during reset is never taken.
   assign o_req_ready = i_rst_n && (r_state == S_IDLE) && !i_pause_req && !r_pause_ack;
   assign w_req_hs    = i_req_valid && o_req_ready;
   assign w_aw_done   = !r_aw_valid || i_aw_ready;
   assign w_w_done    = !r_w_valid || i_w_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_req_hs) w_state_nxt = i_req_we ? S_WR : S_RD;
         S_WR:    if (w_aw_done && w_w_done) w_state_nxt = S_WB;
         S_WB:    if (i_b_valid) w_state_nxt = S_RSP;
         S_RD:    if (i_ar_ready) w_state_nxt = S_RR;
         S_RR:    if (i_r_valid) w_state_nxt = S_RSP;
         S_RSP:   if (i_rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_aw_valid  <= 1'b0;
         r_w_valid   <= 1'b0;
         r_ar_valid  <= 1'b0;
         r_pause_ack <= 1'b0;
         r_addr      <= '0;
         r_prot      <= '0;
         r_wdata     <= '0;
         r_strb      <= '0;
         r_rdata     <= '0;
         r_resp      <= '0;
      end else begin
         r_pause_ack <= i_pause_req && (r_state == S_IDLE);
         if (w_req_hs) begin
            r_addr     <= i_req_addr;
            r_prot     <= i_req_prot;
            r_wdata    <= i_req_wdata;
            r_strb     <= i_req_strb;
            r_aw_valid <= i_req_we;
            r_w_valid  <= i_req_we;
            r_ar_valid <= !i_req_we;
         end
         if (r_aw_valid && i_aw_ready) r_aw_valid <= 1'b0;
         if (r_w_valid && i_w_ready)   r_w_valid  <= 1'b0;
         if (r_ar_valid && i_ar_ready) r_ar_valid <= 1'b0;
         if ((r_state == S_WB) && i_b_valid) begin
            r_rdata <= '0;
            r_resp  <= i_b_resp;
         end
         if ((r_state == S_RR) && i_r_valid) begin
            r_rdata <= i_r_data;
            r_resp  <= i_r_resp;
         end
      end
   end

   assign o_pause_ack = r_pause_ack;
   assign o_aw_addr   = r_addr;
   assign o_aw_prot   = r_prot;
   assign o_aw_valid  = r_aw_valid;
   assign o_w_data    = r_wdata;
   assign o_w_strb    = r_strb;
   assign o_w_valid   = r_w_valid;
   assign o_b_ready   = (r_state == S_WB);
   assign o_ar_addr   = r_addr;
   assign o_ar_prot   = r_prot;
   assign o_ar_valid  = r_ar_valid;
   assign o_r_ready   = (r_state == S_RR);
   assign o_rsp_valid = (r_state == S_RSP);
   assign o_rsp_rdata = r_rdata;
   assign o_rsp_resp  = r_resp;

endmodule

// File: tb/tb_adam_axil_req_mst.sv
// Bench for adam_axil_req_mst: memory-backed AXI-Lite slave with selectable timing,
// reference memory model feeding a response scoreboard, plus AXI-side checks.
module tb_adam_axil_req_mst;

   logic        clk;
   logic        rst_n;
   logic        pause_req, pause_ack;
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_prot;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        req_valid, req_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_valid, rsp_ready;
   logic [31:0] aw_addr;
   logic [2:0]  aw_prot;
   logic        aw_valid, aw_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_valid, w_ready;
   logic [1:0]  b_resp;
   logic        b_valid, b_ready;
   logic [31:0] ar_addr;
   logic [2:0]  ar_prot;
   logic        ar_valid, ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_valid, r_ready;

   adam_axil_req_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pause_req(pause_req), .o_pause_ack(pause_ack),
      .i_req_we(req_we), .i_req_addr(req_addr), .i_req_prot(req_prot),
      .i_req_wdata(req_wdata), .i_req_strb(req_strb), .i_req_valid(req_valid),
      .o_req_ready(req_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_aw_addr(aw_addr), .o_aw_prot(aw_prot), .o_aw_valid(aw_valid), .i_aw_ready(aw_ready),
      .o_w_data(w_data), .o_w_strb(w_strb), .o_w_valid(w_valid), .i_w_ready(w_ready),
      .i_b_resp(b_resp), .i_b_valid(b_valid), .o_b_ready(b_ready),
      .o_ar_addr(ar_addr), .o_ar_prot(ar_prot), .o_ar_valid(ar_valid), .i_ar_ready(ar_ready),
      .i_r_data(r_data), .i_r_resp(r_resp), .i_r_valid(r_valid), .o_r_ready(r_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Address map of the bench slave: 0x0000-0x0FFF memory, 0x8000 SLVERR, 0xC000 DECERR.
   function automatic logic [1:0] resp_of(input logic [31:0] a);
      if (a[15:14] == 2'b11) return 2'b11;
      if (a[15])             return 2'b10;
      return 2'b00;
   endfunction

   // ---------------- AXI-Lite slave ----------------
   int          s_mode;   // 0 zero-wait, 1 random, 2 W ready 4 cycles before AW
   logic [31:0] s_mem [1024];
   logic        s_got_aw, s_got_w, s_got_ar;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   int          s_bwait, s_rwait, s_awcnt;
   logic        s_aw_hs, s_w_hs, s_ar_hs;
   logic [31:0] s_cur_aw, s_cur_wd, s_cur_ar;
   logic [3:0]  s_cur_ws;

   assign s_aw_hs  = aw_valid && aw_ready;
   assign s_w_hs   = w_valid && w_ready;
   assign s_ar_hs  = ar_valid && ar_ready;
   assign s_cur_aw = s_aw_hs ? aw_addr : s_awaddr;
   assign s_cur_wd = s_w_hs ? w_data : s_wdata;
   assign s_cur_ws = s_w_hs ? w_strb : s_wstrb;
   assign s_cur_ar = s_ar_hs ? ar_addr : s_araddr;

   always @(posedge clk) begin
      if (!rst_n) begin
         aw_ready <= 0; w_ready <= 0; ar_ready <= 0;
         b_valid <= 0; b_resp <= 0; r_valid <= 0; r_data <= 0; r_resp <= 0;
         s_got_aw <= 0; s_got_w <= 0; s_got_ar <= 0;
         s_awaddr <= 0; s_wdata <= 0; s_wstrb <= 0; s_araddr <= 0;
         s_bwait <= 0; s_rwait <= 0; s_awcnt <= 0;
         for (int i = 0; i < 1024; i++) s_mem[i] <= '0;
      end else begin
         s_awcnt <= aw_valid ? s_awcnt + 1 : 0;
         case (s_mode)
            0: begin aw_ready <= 1; w_ready <= 1; ar_ready <= 1; end
            1: begin
               aw_ready <= ($urandom_range(0, 2) == 0);
               w_ready  <= ($urandom_range(0, 2) == 0);
               ar_ready <= ($urandom_range(0, 2) == 0);
            end
            default: begin
               w_ready  <= 1;
               ar_ready <= 1;
               aw_ready <= aw_valid && !s_aw_hs && (s_awcnt >= 3);
            end
         endcase
         if (s_aw_hs) s_awaddr <= aw_addr;
         if (s_w_hs) begin s_wdata <= w_data; s_wstrb <= w_strb; end
         if (s_ar_hs) s_araddr <= ar_addr;

         if ((s_got_aw || s_aw_hs) && (s_got_w || s_w_hs) && !b_valid) begin
            if (s_bwait == 0) begin
               b_valid <= 1;
               b_resp  <= resp_of(s_cur_aw);
               if (resp_of(s_cur_aw) == 2'b00)
                  for (int k = 0; k < 4; k++)
                     if (s_cur_ws[k]) s_mem[s_cur_aw[11:2]][8*k +: 8] <= s_cur_wd[8*k +: 8];
               s_got_aw <= 0;
               s_got_w  <= 0;
               s_bwait  <= (s_mode == 1) ? int'($urandom_range(0, 3)) : 0;
            end else begin
               s_bwait  <= s_bwait - 1;
               s_got_aw <= 1;
               s_got_w  <= 1;
            end
         end else begin
            if (s_aw_hs) s_got_aw <= 1;
            if (s_w_hs)  s_got_w  <= 1;
         end
         if (b_valid && b_ready) b_valid <= 0;

         if ((s_got_ar || s_ar_hs) && !r_valid) begin
            if (s_rwait == 0) begin
               r_valid  <= 1;
               r_resp   <= resp_of(s_cur_ar);
               r_data   <= (resp_of(s_cur_ar) == 2'b00) ? s_mem[s_cur_ar[11:2]] : 32'h0;
               s_got_ar <= 0;
               s_rwait  <= (s_mode == 1) ? int'($urandom_range(0, 3)) : 0;
            end else begin
               s_rwait  <= s_rwait - 1;
               s_got_ar <= 1;
            end
         end
         if (r_valid && r_ready) r_valid <= 0;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct { logic [31:0] rdata; logic [1:0] resp; } rsp_t;
   typedef struct { logic [31:0] addr; logic [2:0] prot; logic [31:0] data; logic [3:0] strb; } ax_t;
   rsp_t        exp_q[$];
   ax_t         ax_q[$];
   logic [31:0] m_mem [1024];
   int          n_bhs = 0;

   task automatic model_issue(input logic we, input logic [31:0] a, input logic [2:0] p,
                              input logic [31:0] d, input logic [3:0] s);
      rsp_t r;
      ax_t  x;
      logic [31:0] word;
      r.resp = resp_of(a);
      r.rdata = 32'h0;
      if (we) begin
         if (r.resp == 2'b00) begin
            word = m_mem[a[11:2]];
            for (int k = 0; k < 4; k++) if (s[k]) word[8*k +: 8] = d[8*k +: 8];
            m_mem[a[11:2]] = word;
         end
      end else if (r.resp == 2'b00) begin
         r.rdata = m_mem[a[11:2]];
      end
      exp_q.push_back(r);
      x.addr = a; x.prot = p; x.data = d; x.strb = s;
      ax_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: actual rdata %0h resp %0h, required no response", rsp_rdata, rsp_resp);
         end else begin
            chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
            chk("rsp_resp", rsp_resp, exp_q[0].resp);
            void'(exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if ((s_aw_hs || s_w_hs || s_ar_hs) && ax_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL axi_unexpected: actual channel activity, required none");
         end else if (ax_q.size() != 0) begin
            if (s_aw_hs) chk("aw_payload", {aw_addr, aw_prot}, {ax_q[0].addr, ax_q[0].prot});
            if (s_w_hs)  chk("w_payload", {w_data, w_strb}, {ax_q[0].data, ax_q[0].strb});
            if (s_ar_hs) chk("ar_payload", {ar_addr, ar_prot}, {ax_q[0].addr, ax_q[0].prot});
            if ((b_valid && b_ready) || (r_valid && r_ready)) void'(ax_q.pop_front());
         end
         if (b_valid && b_ready) n_bhs <= n_bhs + 1;
      end
   end

   // A raised valid must stay up with stable payload until its handshake.
   logic        p_ok;
   logic        p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r, p_rs_v, p_rs_r;
   logic [34:0] p_aw, p_ar;
   logic [35:0] p_w;
   logic [33:0] p_rs;
   always @(negedge clk) begin
      if (rst_n && p_ok) begin
         if (p_aw_v && !p_aw_r) chk("aw_hold", {aw_valid, aw_addr, aw_prot}, {1'b1, p_aw});
         if (p_w_v && !p_w_r)   chk("w_hold", {w_valid, w_data, w_strb}, {1'b1, p_w});
         if (p_ar_v && !p_ar_r) chk("ar_hold", {ar_valid, ar_addr, ar_prot}, {1'b1, p_ar});
         if (p_rs_v && !p_rs_r) chk("rsp_hold", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, p_rs});
      end
      p_ok <= rst_n;
      p_aw_v <= aw_valid; p_aw_r <= aw_ready; p_aw <= {aw_addr, aw_prot};
      p_w_v  <= w_valid;  p_w_r  <= w_ready;  p_w  <= {w_data, w_strb};
      p_ar_v <= ar_valid; p_ar_r <= ar_ready; p_ar <= {ar_addr, ar_prot};
      p_rs_v <= rsp_valid; p_rs_r <= rsp_ready; p_rs <= {rsp_rdata, rsp_resp};
   end

   // ---------------- stimulus ----------------
   logic rsp_rand, rsp_force;
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_force;
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic do_req(input logic we, input logic [31:0] a, input logic [2:0] p,
                         input logic [31:0] d, input logic [3:0] s);
      bit done = 0;
      req_we = we; req_addr = a; req_prot = p; req_wdata = d; req_strb = s;
      req_valid = 1'b1;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (req_ready) begin
            model_issue(we, a, p, d, s);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL req_accept_timeout: actual not accepted, required accepted (addr %0h)", a);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain_pending_rsp", 64'(exp_q.size()), 0);
   endtask

   task automatic lat_check(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd);
      do_req(we, a, 3'b010, d, 4'hF);
      @(negedge clk);
      chk("lat_n1_req", we ? {aw_valid, w_valid} : {ar_valid, ar_valid}, 2'b11);
      chk("lat_n1_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      chk("lat_n2_resp_ready", we ? b_ready : r_ready, 1);
      chk("lat_n2_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      chk("lat_n3_rsp_valid", rsp_valid, 1);
      chk("lat_n3_rdata", rsp_rdata, exp_rd);
      chk("lat_n3_resp", rsp_resp, 2'b00);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      bit got;
      int nb;
      for (int i = 0; i < 1024; i++) m_mem[i] = '0;
      rst_n = 0; pause_req = 0; s_mode = 0; rsp_rand = 0; rsp_force = 1;
      req_we = 1; req_addr = 32'h44; req_prot = 0; req_wdata = 32'h1; req_strb = 4'hF;
      req_valid = 1;

      // reset with a pending request
      repeat (5) begin
         @(negedge clk);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_outputs", {aw_valid, w_valid, ar_valid, rsp_valid, b_ready, r_ready, pause_ack}, 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      req_valid = 0;
      @(negedge clk);
      chk("rst_release_req_ready", req_ready, 1);
      @(posedge clk);
      #1;

      // write/read with zero-wait slave and 3-cycle latency
      lat_check(1, 32'h10, 32'hCAFEF00D, 32'h0);
      lat_check(0, 32'h10, 32'h0, 32'hCAFEF00D);

      // W ready four cycles before AW ready
      s_mode = 2;
      nb = n_bhs;
      do_req(1, 32'h20, 3'b001, 32'hA5A55A5A, 4'hF);
      @(negedge clk);
      chk("skew_first_cycle", {aw_valid, aw_ready, w_valid, w_ready}, 4'b1011);
      @(negedge clk);
      chk("skew_w_dropped", {aw_valid, w_valid}, 2'b10);
      drain();
      chk("skew_b_count", 64'(n_bhs - nb), 1);
      s_mode = 0;
      do_req(0, 32'h20, 3'b001, 32'h0, 4'h0);
      drain();

      // response backpressure
      do_req(1, 32'h40, 3'b000, 32'h12345678, 4'hF);
      drain();
      rsp_force = 0;
      do_req(0, 32'h40, 3'b000, 32'h0, 4'h0);
      got = 0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      chk("bp_rsp_seen", got, 1);
      repeat (10) begin
         chk("bp_hold", {rsp_valid, rsp_rdata, rsp_resp, req_ready}, {1'b1, 32'h12345678, 2'b00, 1'b0});
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_force = 1;
      drain();

      // pause while idle
      pause_req = 1;
      @(negedge clk);
      chk("pause_idle_first", {pause_ack, req_ready}, 2'b00);
      @(negedge clk);
      chk("pause_idle_ack", pause_ack, 1);
      @(posedge clk);
      #1;
      pause_req = 0;
      @(posedge clk);
      #1;

      // pause raised in the middle of a read
      s_mode = 1;
      do_req(0, 32'h10, 3'b100, 32'h0, 4'h0);
      pause_req = 1;
      got = 0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (rsp_valid) chk("pause_ack_while_busy", pause_ack, 0);
         if (pause_ack) got = 1;
      end
      chk("pause_mid_ack_seen", got, 1);
      chk("pause_mid_rsp_done", 64'(exp_q.size()), 0);
      @(posedge clk);
      #1;
      req_we = 0; req_addr = 32'h10; req_valid = 1;
      repeat (5) begin
         @(negedge clk);
         chk("pause_blocks_req", {req_ready, pause_ack}, 2'b01);
      end
      @(posedge clk);
      #1;
      pause_req = 0;
      req_valid = 0;
      @(negedge clk);
      chk("unpause_same_cycle", {pause_ack, req_ready}, 2'b10);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("unpause_next_cycle", {pause_ack, req_ready}, 2'b01);
      @(posedge clk);
      #1;

      // full sweep: data = address, then read back, random slave timing
      rsp_rand = 1;
      for (int i = 0; i < 1024; i++) begin
         a = 32'(i * 4);
         do_req(1, a, 3'($urandom_range(0, 7)), a, 4'hF);
      end
      for (int i = 0; i < 1024; i++) begin
         a = 32'(i * 4);
         do_req(0, a, 3'($urandom_range(0, 7)), 32'h0, 4'h0);
      end
      drain();

      // error regions
      do_req(1, 32'h8000, 3'b000, 32'hDEADBEEF, 4'hF);
      do_req(0, 32'h8010, 3'b000, 32'h0, 4'h0);
      do_req(1, 32'hC004, 3'b000, 32'h1, 4'h3);
      do_req(0, 32'hC008, 3'b000, 32'h0, 4'h0);
      drain();

      // random mix with partial strobes
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0:       a = 32'h8000 | {18'h0, 12'($urandom_range(0, 1023)), 2'b00};
            1:       a = 32'hC000 | {18'h0, 12'($urandom_range(0, 1023)), 2'b00};
            default: a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         endcase
         do_req(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      end
      drain();
      chk("final_axi_queue", 64'(ax_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
